// File: rtl/scazator_cla_secvential.sv
// Multi-cycle subtractor: Diferenta = A - B - B_in, one 4-bit carry look-ahead slice per cycle, LSB first.
// Optional macro SCAZATOR_OVF_EN adds a registered signed-overflow output OVF.
module scazator_cla_secvential #(
  parameter int LATIME = 16,
  parameter int NIBBLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LATIME-1:0] A,
  input  logic [LATIME-1:0] B,
  input  logic              B_in,
  output logic [LATIME-1:0] Diferenta,
  output logic              B_out,
  output logic              busy,
  output logic              done
`ifdef SCAZATOR_OVF_EN
  ,
  output logic              OVF
`endif
);

  localparam int NSLICE = LATIME / NIBBLE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LATIME-1:0] a_q, a_d;
  logic [LATIME-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic [LATIME-1:0] dif_q, dif_d;
  logic              bout_q, bout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SCAZATOR_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [NIBBLE-1:0] nib_a, nib_nb, g, p, sum;
  logic [NIBBLE:0]   c;

  // Subtraction as A + ~B + carry; carries are two-level look-ahead, no ripple.
  always_comb begin
    nib_a  = a_q[k_q*NIBBLE +: NIBBLE];
    nib_nb = ~b_q[k_q*NIBBLE +: NIBBLE];
    g      = nib_a & nib_nb;
    p      = nib_a ^ nib_nb;
    c[0]   = carry_q;
    c[1]   = g[0] | (p[0] & carry_q);
    c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry_q);
    c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
    sum    = p ^ c[NIBBLE-1:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    dif_d   = dif_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SCAZATOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~B_in;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dif_d[k_q*NIBBLE +: NIBBLE] = sum;
        carry_d = c[NIBBLE];
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NSLICE - 1)) begin
          bout_d  = ~c[NIBBLE];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SCAZATOR_OVF_EN
          ovf_d   = (a_q[LATIME-1] != b_q[LATIME-1]) && (sum[NIBBLE-1] != a_q[LATIME-1]);
`endif
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      dif_q   <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAZATOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      dif_q   <= dif_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAZATOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Diferenta = dif_q;
  assign B_out     = bout_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SCAZATOR_OVF_EN
  assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_scazator_cla_secvential.sv
// Bench for scazator_cla_secvential: arithmetic/timing reference model plus directed literal checks.
// Define SCAZATOR_OVF_EN to also exercise the OVF output.
module tb_scazator_cla_secvential;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        B_in = 1'b0;
  logic [15:0] Diferenta;
  logic        B_out, busy, done;
`ifdef SCAZATOR_OVF_EN
  logic        OVF;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  scazator_cla_secvential #(.LATIME(16), .NIBBLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .B_in(B_in),
    .Diferenta(Diferenta), .B_out(B_out), .busy(busy), .done(done)
`ifdef SCAZATOR_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: rem counts cycles left until the block is idle again (0 = idle).
  int          rem = 0;
  logic [15:0] pend_d = '0, exp_d = '0;
  logic        pend_b = 1'b0, exp_b = 1'b0;
  logic        pend_o = 1'b0, exp_o = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; exp_d = '0; exp_b = 1'b0; exp_o = 1'b0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 1) begin
        exp_d = pend_d; exp_b = pend_b; exp_o = pend_o;
      end
    end else if (start) begin
      int diff;
      diff   = int'(A) - int'(B) - int'(B_in);
      pend_d = diff[15:0];
      pend_b = (diff < 0);
      pend_o = (A[15] != B[15]) && (pend_d[15] != A[15]);
      rem    = 5;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(rem >= 2));
      chk("done", 32'(done), 32'(rem == 1));
      if (rem <= 1) begin
        chk("Diferenta", 32'(Diferenta), 32'(exp_d));
        chk("B_out", 32'(B_out), 32'(exp_b));
`ifdef SCAZATOR_OVF_EN
        chk("OVF", 32'(OVF), 32'(exp_o));
`endif
      end
      if (done) $display("txn: Diferenta=%h B_out=%0d", Diferenta, B_out);
    end
  end

  // Runs one operation from idle and pins the result and latency to literal values.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                    input logic [15:0] ed, input logic eb, input logic eo, input string nm);
    int lat;
    @(posedge clk); #2;
    A = a; B = b; B_in = bi; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    A = 16'(~a); B = 16'(~b); B_in = ~bi;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'd4);
    chk({nm, "_dif"}, 32'(Diferenta), 32'(ed));
    chk({nm, "_bout"}, 32'(B_out), 32'(eb));
`ifdef SCAZATOR_OVF_EN
    chk({nm, "_ovf"}, 32'(OVF), 32'(eo));
`else
    if (eo) ;
`endif
    @(posedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dif", 32'(Diferenta), 32'd0);
    chk("rst_bout", 32'(B_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_en = 1'b1;
    #20 rst_n = 1'b1;

    op(16'd10, 16'd2, 1'b0, 16'd8, 1'b0, 1'b0, "10m2");
    op(16'd5, 16'd12, 1'b1, 16'hFFF8, 1'b1, 1'b0, "5m12m1");
    op(16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "0m0m1");
    op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, "ffff");

    // start held high: operands disturbed while busy must not matter
    @(posedge clk); #2;
    A = 16'd20; B = 16'd7; B_in = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    A = 16'($urandom); B = 16'($urandom); B_in = 1'($urandom);
    repeat (2) @(posedge clk);
    #2 A = 16'd20; B = 16'd7; B_in = 1'b0;
    wait_done(n);
    chk("hold_dif1", 32'(Diferenta), 32'd13);
    wait_done(n);
    chk("hold_period", 32'(n), 32'd6);
    chk("hold_dif2", 32'(Diferenta), 32'd13);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);

    // async reset mid-calculation
    @(posedge clk); #2;
    A = 16'd1234; B = 16'd5; B_in = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_dif", 32'(Diferenta), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bout", 32'(B_out), 32'd0);
    #6 rst_n = 1'b1;
    op(16'd100, 16'd1, 1'b0, 16'd99, 1'b0, 1'b0, "100m1");

`ifdef SCAZATOR_OVF_EN
    op(16'h8000, 16'd1, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf1");
    op(16'd3, 16'd5, 1'b0, 16'hFFFE, 1'b1, 1'b0, "ovf0");
`endif

    // random traffic: start and operands toggle every cycle, model tracks acceptance
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) != 0);
      A = 16'($urandom); B = 16'($urandom); B_in = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        A[15:8] = 8'h00; B[15:8] = 8'h00;
      end
    end
    @(posedge clk); #2 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
